// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped console / halt port.
package mmio_pkg;

  localparam logic [31:0] DEFAULT_CONSOLE_ADR = 32'h0000_FFF0;
  localparam logic [31:0] DEFAULT_HALT_ADR    = 32'h0000_FFF4;

  // 8N1 framing
  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_STOP_BITS = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO is taken
// only when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count_c = wr_ptr - rd_ptr;
  assign data_c  = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop_i && !empty_c;
  assign do_push = push_i && (!full_c || do_pop);

  // Pointer update; pointers wrap naturally through the extra MSB
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; read side is a combinational look-up at rd_ptr
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/mmio_console.sv
// Console/halt port snooping the CPU store bus: console bytes go through a
// FIFO into an 8N1 UART transmitter, halt stores latch a sticky exit code.
module mmio_console
  import mmio_pkg::*;
#(
  parameter logic [31:0] CONSOLE_ADR  = DEFAULT_CONSOLE_ADR,
  parameter logic [31:0] HALT_ADR     = DEFAULT_HALT_ADR,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mem_write_i,
  input  logic [31:0] data_adr_i32,
  input  logic [31:0] write_data_i32,
  output logic        tx_o,
  output logic        busy_o,
  output logic        overflow_o,
  output logic        halt_o,
  output logic [7:0]  halt_code_o8
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(UART_DATA_BITS);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  tx_state_t                 state, state_n;
  logic [UART_DATA_BITS-1:0] shift, shift_n;
  logic [CW-1:0]             bit_cnt, cnt_n;
  logic [IW-1:0]             bit_idx, idx_n;
  logic                      tx_n;
  logic                      busy_n;
  logic                      last_tick;

  logic                      console_hit;
  logic                      halt_hit;
  logic                      pop;
  logic                      push_ok;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [AW:0]               fifo_count;
  logic [AW:0]               count_next;
  logic [UART_DATA_BITS-1:0] fifo_data;
  logic                      unused_data;

  assign console_hit = mem_write_i && (data_adr_i32 == CONSOLE_ADR);
  assign halt_hit    = mem_write_i && (data_adr_i32 == HALT_ADR);
  assign pop         = (state == ST_IDLE) && !fifo_empty;
  assign push_ok     = console_hit && (!fifo_full || pop);
  assign count_next  = fifo_count + (AW+1)'(push_ok) - (AW+1)'(pop);
  assign last_tick   = (bit_cnt == CW'(CLKS_PER_BIT - 1));
  assign unused_data = ^write_data_i32[31:8];

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push_ok),
    .pop_i   (pop),
    .data_i  (write_data_i32[UART_DATA_BITS-1:0]),
    .data_c  (fifo_data),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count_c (fifo_count)
  );

  // TX state and registered line/busy outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= ST_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      bit_idx <= '0;
      tx_o    <= 1'b1;
      busy_o  <= 1'b0;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_cnt <= cnt_n;
      bit_idx <= idx_n;
      tx_o    <= tx_n;
      busy_o  <= busy_n;
    end
  end

  // Next-state logic; tx_n is the line level for the cycle after the edge
  always_comb begin
    state_n = state;
    shift_n = shift;
    cnt_n   = bit_cnt;
    idx_n   = bit_idx;
    tx_n    = tx_o;
    case (state)
      ST_IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          shift_n = fifo_data;
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = 1'b0;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (last_tick) begin
          cnt_n   = '0;
          tx_n    = shift[0];
          state_n = ST_DATA;
        end else begin
          cnt_n = bit_cnt + CW'(1);
        end
      end
      ST_DATA: begin
        if (last_tick) begin
          cnt_n = '0;
          if (bit_idx == IW'(UART_DATA_BITS - 1)) begin
            idx_n   = '0;
            tx_n    = 1'b1;
            state_n = ST_STOP;
          end else begin
            idx_n   = bit_idx + IW'(1);
            shift_n = {1'b0, shift[UART_DATA_BITS-1:1]};
            tx_n    = shift_n[0];
          end
        end else begin
          cnt_n = bit_cnt + CW'(1);
        end
      end
      ST_STOP: begin
        tx_n = 1'b1;
        if (last_tick) begin
          cnt_n = '0;
          if (bit_idx == IW'(UART_STOP_BITS - 1)) begin
            state_n = ST_IDLE;
          end else begin
            idx_n = bit_idx + IW'(1);
          end
        end else begin
          cnt_n = bit_cnt + CW'(1);
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = ST_IDLE;
      end
    endcase
    busy_n = (count_next != '0) || (state_n != ST_IDLE);
  end

  // Sticky overflow and halt flags; only the first halt store sets the code
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overflow_o   <= 1'b0;
      halt_o       <= 1'b0;
      halt_code_o8 <= 8'h00;
    end else begin
      if (console_hit && fifo_full && !pop) overflow_o <= 1'b1;
      if (halt_hit) begin
        halt_o <= 1'b1;
        if (!halt_o) halt_code_o8 <= write_data_i32[7:0];
      end
    end
  end

endmodule

// File: tb/tb_mmio_console.sv
// Bench for mmio_console: a UART frame monitor checks received bytes against
// a scoreboard queue filled as console stores are driven.
module tb_mmio_console;

  localparam logic [31:0] CON_ADR  = 32'h0000_FFF0;
  localparam logic [31:0] HALT_ADR = 32'h0000_FFF4;

  logic        clk_i;
  logic        reset_i;
  logic        mem_write_i;
  logic [31:0] data_adr_i32;
  logic [31:0] write_data_i32;
  logic        tx_o;
  logic        busy_o;
  logic        overflow_o;
  logic        halt_o;
  logic [7:0]  halt_code_o8;

  int errs;
  int checks;
  logic [7:0] sb [$];

  mmio_console #(
    .CONSOLE_ADR  (CON_ADR),
    .HALT_ADR     (HALT_ADR),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .mem_write_i    (mem_write_i),
    .data_adr_i32   (data_adr_i32),
    .write_data_i32 (write_data_i32),
    .tx_o           (tx_o),
    .busy_o         (busy_o),
    .overflow_o     (overflow_o),
    .halt_o         (halt_o),
    .halt_code_o8   (halt_code_o8)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] data);
    mem_write_i    = we;
    data_adr_i32   = adr;
    write_data_i32 = data;
  endtask

  // One store sampled on the next edge; returns at the negedge after it
  task automatic store(input logic [31:0] adr, input logic [31:0] data);
    drive(1'b1, adr, data);
    @(negedge clk_i);
    drive(1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk_i);
    check("rst_tx",       32'(tx_o),         32'd1);
    check("rst_busy",     32'(busy_o),       32'd0);
    check("rst_overflow", 32'(overflow_o),   32'd0);
    check("rst_halt",     32'(halt_o),       32'd0);
    check("rst_code",     32'(halt_code_o8), 32'd0);
    reset_i = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (busy_o && n < max_cycles) begin
      @(negedge clk_i);
      n++;
    end
    check("idle_timeout", 32'(busy_o), 32'd0);
    repeat (3) @(negedge clk_i);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  // UART receiver: frame starts on the first low sample, bits sampled mid-cell
  initial begin : uart_mon
    logic [7:0] rx;
    logic [7:0] exp_b;
    logic       aborted;
    logic       start_bit;
    logic       stop_bit;
    forever begin
      @(negedge clk_i);
      if (tx_o === 1'b0 && !reset_i) begin
        rx        = 8'h00;
        aborted   = 1'b0;
        start_bit = 1'b1;
        stop_bit  = 1'b0;
        for (int c = 1; c < 40; c++) begin
          @(negedge clk_i);
          if (reset_i) aborted = 1'b1;
          if (c == 2) start_bit = tx_o;
          if (c >= 6 && c <= 34 && ((c - 6) % 4) == 0) rx[(c - 6) / 4] = tx_o;
          if (c == 38) stop_bit = tx_o;
        end
        if (!aborted) begin
          check("frame_start", 32'(start_bit), 32'd0);
          check("frame_stop",  32'(stop_bit),  32'd1);
          check("frame_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            exp_b = sb.pop_front();
            check("frame_byte", 32'(rx), 32'(exp_b));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [9:0] fr;
    int lows;
    int busys;
    errs   = 0;
    checks = 0;
    reset_i = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk_i);
    do_reset();

    // Single byte: exact waveform and busy timing
    store(CON_ADR, 32'h0000_0141);
    sb.push_back(8'h41);
    check("t1_tx_before_pop", 32'(tx_o),   32'd1);
    check("t1_busy_on_push",  32'(busy_o), 32'd1);
    fr = {1'b1, 8'h41, 1'b0};
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      check("t1_tx_wave", 32'(tx_o), 32'(fr[c / 4]));
      if (c == 39) check("t1_busy_last", 32'(busy_o), 32'd1);
    end
    @(negedge clk_i);
    check("t1_busy_drop", 32'(busy_o), 32'd0);
    check("t1_tx_idle",   32'(tx_o),   32'd1);
    wait_idle(100);

    // Overflow: six back-to-back stores, the sixth is dropped
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k == 1) check("t2_tx_e1", 32'(tx_o), 32'd1);
      if (k == 2) check("t2_pop_e2", 32'(tx_o), 32'd0);
      if (k == 5) check("t2_ovf_before", 32'(overflow_o), 32'd0);
      drive(1'b1, CON_ADR, 32'(65 + k));
      if (k < 5) sb.push_back(8'(65 + k));
      @(negedge clk_i);
    end
    drive(1'b0, 32'h0, 32'h0);
    check("t2_ovf_set", 32'(overflow_o), 32'd1);
    wait_idle(1000);
    check("t2_ovf_sticky", 32'(overflow_o), 32'd1);

    // Push on the same edge as the IDLE pop with the FIFO full
    do_reset();
    drive(1'b1, CON_ADR, 32'h58);
    sb.push_back(8'h58);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      drive(1'b1, CON_ADR, 32'(97 + k));
      sb.push_back(8'(97 + k));
    end
    @(negedge clk_i);
    drive(1'b0, 32'h0, 32'h0);
    repeat (36) @(negedge clk_i);
    check("t3_stop", 32'(tx_o), 32'd1);
    @(negedge clk_i);
    check("t3_idle", 32'(tx_o), 32'd1);
    drive(1'b1, CON_ADR, 32'h5A);
    sb.push_back(8'h5A);
    @(negedge clk_i);
    drive(1'b0, 32'h0, 32'h0);
    check("t3_popped", 32'(tx_o), 32'd0);
    check("t3_no_ovf", 32'(overflow_o), 32'd0);
    wait_idle(1000);
    check("t3_no_ovf_end", 32'(overflow_o), 32'd0);

    // Halt: first code kept, console still accepted afterwards
    do_reset();
    store(HALT_ADR, 32'h0000_0007);
    check("t4_halt", 32'(halt_o), 32'd1);
    check("t4_code", 32'(halt_code_o8), 32'h07);
    store(HALT_ADR, 32'h0000_0009);
    check("t4_halt2", 32'(halt_o), 32'd1);
    check("t4_code_kept", 32'(halt_code_o8), 32'h07);
    store(CON_ADR, 32'h0000_0048);
    sb.push_back(8'h48);
    wait_idle(100);
    check("t4_halt_end", 32'(halt_o), 32'd1);

    // Reset during DATA bit 3 with two bytes queued
    do_reset();
    drive(1'b1, CON_ADR, 32'h00);
    @(negedge clk_i);
    drive(1'b1, CON_ADR, 32'h55);
    @(negedge clk_i);
    drive(1'b1, CON_ADR, 32'hAA);
    @(negedge clk_i);
    drive(1'b1, HALT_ADR, 32'h3C);
    @(negedge clk_i);
    drive(1'b0, 32'h0, 32'h0);
    repeat (15) @(negedge clk_i);
    check("t5_mid_bit3", 32'(tx_o), 32'd0);
    check("t5_busy_pre", 32'(busy_o), 32'd1);
    check("t5_halt_pre", 32'(halt_o), 32'd1);
    reset_i = 1'b1;
    @(negedge clk_i);
    check("t5_tx",   32'(tx_o),         32'd1);
    check("t5_busy", 32'(busy_o),       32'd0);
    check("t5_ovf",  32'(overflow_o),   32'd0);
    check("t5_halt", 32'(halt_o),       32'd0);
    check("t5_code", 32'(halt_code_o8), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    lows  = 0;
    busys = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk_i);
      if (!tx_o) lows++;
      if (busy_o) busys++;
    end
    check("t5_no_frames", 32'(lows),  32'd0);
    check("t5_no_busy",   32'(busys), 32'd0);

    // Decode: neighbouring addresses and a non-write cycle do nothing
    do_reset();
    store(32'h0000_FFEC, 32'h31);
    store(32'h0000_FFF8, 32'h32);
    drive(1'b0, CON_ADR, 32'h33);
    @(negedge clk_i);
    drive(1'b0, 32'h0, 32'h0);
    lows  = 0;
    busys = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_i);
      if (!tx_o) lows++;
      if (busy_o) busys++;
    end
    check("t6_tx_high", 32'(lows),       32'd0);
    check("t6_no_busy", 32'(busys),      32'd0);
    check("t6_no_halt", 32'(halt_o),     32'd0);
    check("t6_no_ovf",  32'(overflow_o), 32'd0);
    check("t6_sb",      32'(sb.size()),  32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mmio_console.md
# mmio_console

Memory-mapped console and halt port sitting directly downstream of the single-cycle MIPS top level. It snoops the processor's data-memory write bus (`mem_write`, `data_adr`, `write_data`). Byte writes to a console address are buffered in a small FIFO and serialized as 8N1 UART frames. A write to a halt address latches a completion flag and exit code for the testbench and the board.

## Interface
- `CONSOLE_ADR`, default 32'h0000_FFF0: store address whose low byte is sent to the UART.
- `HALT_ADR`, default 32'h0000_FFF4: store address that raises halt.
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit. Must be ≥ 2.
- `FIFO_DEPTH`, default 16: FIFO entries. Must be a power of two, ≥ 2.

Ports:
- `clk_i` input 1: single clock, all logic on the rising edge.
- `reset_i` input 1: synchronous, active-high reset.
- `mem_write_i` input 1: processor store strobe.
- `data_adr_i32` input 32: store address, compared as a full 32-bit match.
- `write_data_i32` input 32: store data. Only bits [7:0] are used.
- `tx_o` output 1: UART line, idle high, registered.
- `busy_o` output 1: FIFO non-empty or frame in progress.
- `overflow_o` output 1: sticky; a console byte was dropped.
- `halt_o` output 1: sticky; halt write seen.
- `halt_code_o8` output 8: data[7:0] of the first halt write.

## Operation
- Reset values: `tx_o`=1, `busy_o`=0, `overflow_o`=0, `halt_o`=0, `halt_code_o8`=0. FIFO is emptied and the FSM goes to IDLE.
- Push: on an edge where `mem_write_i` is high and `data_adr_i32`==`CONSOLE_ADR`, push `write_data_i32[7:0]`.
  - If the FIFO is full and no pop occurs on the same edge, drop the byte and set `overflow_o`.
  - If the FIFO is full and a pop occurs on the same edge, accept the push; the count is unchanged.
- Halt: on a store to `HALT_ADR`, set `halt_o`. Load `halt_code_o8` only if `halt_o` was 0; later halt writes are ignored.
  - Console stores are still accepted after halt.
- Other addresses: no effect. The block never stalls the processor.
- TX FSM states: IDLE, START, DATA, STOP. A bit counter counts 0..CLKS_PER_BIT-1; a bit index counts 0..7.
  - IDLE: `tx_o`=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `tx_o`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx_o`=shift[0], LSB first. Shift every CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: `tx_o`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- `busy_o` = (FIFO count ≠ 0) OR (state ≠ IDLE). It is registered and consistent with state on the same cycle.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide. Pointers wrap naturally. Full/empty are decided by MSB comparison.

## Timing
- Store sampled at edge N with the FSM in IDLE and the FIFO empty: pop at edge N+1; `tx_o` falls after edge N+1.
- Frame length: 10×CLKS_PER_BIT cycles.
- Back-to-back bytes: exactly one IDLE cycle (`tx_o`=1) between a STOP and the next START. Frame period is 10×CLKS_PER_BIT+1.
- `halt_o` and `overflow_o` rise the cycle after the sampling edge.
- Reset asserted mid-frame: at the next edge `tx_o`=1, the FSM is in IDLE, the FIFO is empty, and all flags are cleared. The partial frame is abandoned.
- A store and reset on the same edge: reset wins and the store is lost.

## Structure
- Package `mmio_pkg`:
  - default `CONSOLE_ADR`/`HALT_ADR` constants
  - `tx_state_t` enum (IDLE, START, DATA, STOP)
  - UART frame constants (8 data bits, 1 stop bit)
- Sub-module `sync_fifo`: parameterised width/depth, with push/pop/full/empty/count. It is reusable elsewhere in the system.
- `mmio_console` holds the address decode, sticky flags and TX FSM.
- The parent top level instantiates it beside `dmem`, wired to the same store bus.

## Test plan
Unless stated otherwise, the bench uses CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- Single byte: store 32'h0000_0141 to FFF0.
  - Required: `tx_o` low after the next edge for 4 cycles, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then 4 high.
  - Required: `busy_o` drops after 40 frame cycles + 1.
- Overflow: 6 consecutive stores of 'A'..'F' while idle.
  - Required: the first byte is popped at the second edge; 'A','B','C','D','E' are transmitted.
  - Required: 'F' is dropped and `overflow_o`=1.
- Simultaneous push/pop: with the FIFO full, store on the exact edge where IDLE pops.
  - Required: the byte is accepted and `overflow_o` stays 0.
- Halt: store 32'h0000_0007 to FFF4, then 32'h0000_0009 to FFF4.
  - Required: `halt_o`=1 and `halt_code_o8`=8'h07, kept after the second store.
- Reset mid-frame: assert `reset_i` during DATA bit 3 with 2 bytes queued.
  - Required: at the next edge `tx_o`=1, `busy_o`=0, `overflow_o`=0, and no further frames.
- Decode: stores to FFEC/FFF8, and a read cycle with the FFF0 address but `mem_write_i`=0.
  - Required: no FIFO change, `tx_o` stays 1.
